nonce_dispatcher: RTL
=====================

Name: nonce_dispatcher

Overview:
- Schedules the current mining job across NUM_CORES hash cores in the hash_clk domain.
- Slices the job nonce range [nonce_min, nonce_max] into CHUNK-sized sub-ranges and hands each sub-range to an idle core.
- Collects golden nonces from all cores through a round-robin arbiter.
- Sits between the UART job/nonce interface (new_work pulse, golden_nonce/new_golden_nonce toggle) and the core array.

Parameters:
- NUM_CORES, 4, number of hash cores served.
- CHUNK_LOG2, 16, log2 of nonces per dispatched chunk; range 1..31.

Ports:
- hash_clk  in  1  hash clock domain.
- rst  in  1  synchronous, active-high reset.
- new_work  in  1  one-cycle pulse: a new job is valid on nonce_min/nonce_max.
- nonce_min  in  32  first nonce of job, inclusive.
- nonce_max  in  32  last nonce of job, inclusive.
- core_start  out  NUM_CORES  one-cycle pulse per core: take chunk now.
- core_abort  out  1  one-cycle pulse: all cores drop current chunk.
- core_nonce_base  out  32  first nonce of chunk; valid with core_start, shared bus.
- core_nonce_last  out  32  last nonce of chunk, inclusive; valid with core_start.
- core_done  in  NUM_CORES  one-cycle pulse: core finished its chunk.
- core_found  in  NUM_CORES  one-cycle pulse: core found a golden nonce.
- core_nonce  in  32*NUM_CORES  nonce for core i at [32i+31:32i]; valid with core_found[i].
- golden_nonce  out  32  last reported golden nonce.
- new_golden_nonce  out  1  toggles once per reported nonce.
- job_done  out  1  one-cycle pulse: range exhausted and all cores idle.
- busy  out  1  high in any state but IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - assigned mask 0, pending mask 0, next_nonce 0, state IDLE.
- States:
  - IDLE: wait for new_work.
  - DISPATCH: range not exhausted.
  - DRAIN: range exhausted, waiting for cores.
- Job load:
  - new_work latches next_nonce = {1'b0, nonce_min} (33 bit) and last = nonce_max.
  - State goes to DISPATCH.
  - If nonce_min > nonce_max, go to DRAIN instead: empty job.
- Dispatch, in DISPATCH, once per cycle:
  - Pick the lowest-index unassigned core at or after rr_dispatch_ptr, wrapping.
  - Drive core_start[i], core_nonce_base = next_nonce[31:0], core_nonce_last = min(next_nonce + 2^CHUNK_LOG2 - 1, last).
  - Set assigned[i] and advance the pointer to i+1 mod NUM_CORES.
  - next_nonce += 2^CHUNK_LOG2, computed in 33 bits so nonce_max = FFFFFFFF cannot wrap.
  - When next_nonce > last, go to DRAIN.
  - If no core is free, stall with no start pulse.
- Latency:
  - new_work at cycle T gives the first core_start at T+1.
  - At most one start per cycle.
- core_done[i]:
  - Clears assigned[i] next cycle.
  - done and dispatch to the same core in the same cycle: done is taken first, so the core is eligible that cycle.
- DRAIN to IDLE:
  - Happens when the assigned mask is 0 and no core_done is pending.
  - job_done pulses for one cycle on that transition.
- new_work while busy (abort):
  - Same cycle: core_abort pulses, assigned mask clears, pending found mask clears, new job loads.
  - First start of the new job at T+1.
- Found collection:
  - core_found[i] latches core_nonce[i] into a per-core holding register and sets pending[i].
  - Each cycle, round-robin arbitration over pending picks at most one entry.
  - The winner goes to golden_nonce, new_golden_nonce toggles, and pending clears.
  - found[i] arriving in the same cycle pending[i] is granted: set wins, and the new nonce is reported later.
- Found pulses are accepted in every state, including IDLE after job_done. Results are never dropped except on abort or rst.
- rst mid-operation: all state returns to reset values in the next cycle. No start, abort or job_done pulse on the reset cycle.

Decomposition:
- Shared package holds:
  - NONCE_W = 32.
  - State encodings IDLE/DISPATCH/DRAIN as one-hot localparams, consistent with the comm state style.
  - Default NUM_CORES.
- Sub-module rr_arbiter (params N; ports: req, advance, grant one-hot, grant_idx). Instantiated twice: dispatch selection and found reporting.

Test Plan:
- Basic dispatch: NUM_CORES=4, CHUNK_LOG2=4, min=0x100, max=0x13F -> starts at cores 0,1,2,3 with base 0x100/0x110/0x120/0x130 and last 0x10F/0x11F/0x12F/0x13F on consecutive cycles. Return all core_done -> job_done pulses once, busy drops.
- Partial last chunk and wrap: min=0xFFFFFFF8, max=0xFFFFFFFF, CHUNK_LOG2=4 -> single start, base FFFFFFF8, last FFFFFFFF, then DRAIN. No second start, no wrap to 0.
- Empty job: min=0x20, max=0x10 -> no core_start; job_done one cycle after the DRAIN entry.
- Backpressure: 2 cores, 5-chunk range -> third start only after a core_done. done and start to the same core in the same cycle -> start accepted.
- Simultaneous finds: core_found=4'b1011 in one cycle with nonces A,B,D -> three reports on consecutive cycles in rr order. new_golden_nonce toggles three times, golden_nonce ends at the last granted value.
- Abort: new_work mid-DISPATCH with finds pending -> core_abort pulse, pending cleared (no toggle), first start of new job at T+1 with base = new nonce_min.

Source files
------------

// File: rtl/nonce_dispatcher_pkg.sv
// Shared widths, defaults and state encoding for the nonce dispatcher.
package nonce_dispatcher_pkg;

    localparam int unsigned NONCE_W           = 32;
    localparam int unsigned DEFAULT_NUM_CORES = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b001,
        ST_DISPATCH = 3'b010,
        ST_DRAIN    = 3'b100
    } disp_state_e;

endpackage

// File: rtl/nonce_dispatcher_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// pointer moves past the winner when advance is high.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_w;
    int unsigned      idx;
    logic             hit;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        hit       = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            idx_w = IDX_W'(idx);
            if (!hit && req[idx_w]) begin
                hit          = 1'b1;
                grant[idx_w] = 1'b1;
                grant_idx    = idx_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && hit) begin
            ptr_q <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// Slices the job nonce range into chunks for idle hash cores and funnels
// golden nonces from all cores back to the comm side.
module nonce_dispatcher
    import nonce_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_CORES  = DEFAULT_NUM_CORES,
    parameter int unsigned CHUNK_LOG2 = 16
) (
    input  logic                           hash_clk,
    input  logic                           rst,
    input  logic                           new_work,
    input  logic [NONCE_W-1:0]             nonce_min,
    input  logic [NONCE_W-1:0]             nonce_max,
    output logic [NUM_CORES-1:0]           core_start,
    output logic                           core_abort,
    output logic [NONCE_W-1:0]             core_nonce_base,
    output logic [NONCE_W-1:0]             core_nonce_last,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_found,
    input  logic [NONCE_W*NUM_CORES-1:0]   core_nonce,
    output logic [NONCE_W-1:0]             golden_nonce,
    output logic                           new_golden_nonce,
    output logic                           job_done,
    output logic                           busy
);

    localparam int unsigned NEXT_W = NONCE_W + 1;
    localparam int unsigned IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [NEXT_W-1:0] CHUNK_SIZE = NEXT_W'(1) << CHUNK_LOG2;

    disp_state_e          state_q, state_d;
    logic [NEXT_W-1:0]    next_q;
    logic [NONCE_W-1:0]   last_q;
    logic [NUM_CORES-1:0] assigned_q;
    logic [NUM_CORES-1:0] pending_q;
    logic [NONCE_W-1:0]   hold_q [NUM_CORES];
    logic                 job_done_d;

    logic                 abort;
    logic [NEXT_W-1:0]    eff_next;
    logic [NONCE_W-1:0]   eff_last;
    logic [NUM_CORES-1:0] eff_assigned;
    logic                 eff_dispatch;
    logic [NUM_CORES-1:0] disp_req, disp_grant, start_vec;
    logic [IDX_W-1:0]     disp_idx;
    logic                 do_start;
    logic [NEXT_W-1:0]    chunk_end, next_adv;
    logic [NONCE_W-1:0]   chunk_last;
    logic [NUM_CORES-1:0] rep_grant;
    logic [IDX_W-1:0]     rep_idx;

    // A new job bypasses the registered job so its first chunk leaves next cycle.
    always_comb begin
        abort = new_work && (state_q != ST_IDLE);
        if (new_work) begin
            eff_next     = {1'b0, nonce_min};
            eff_last     = nonce_max;
            eff_assigned = '0;
            eff_dispatch = (nonce_min <= nonce_max);
        end else begin
            eff_next     = next_q;
            eff_last     = last_q;
            eff_assigned = assigned_q & ~core_done;
            eff_dispatch = (state_q == ST_DISPATCH);
        end
    end

    assign disp_req   = eff_dispatch ? ~eff_assigned : '0;
    assign do_start   = eff_dispatch && (|disp_grant);
    assign start_vec  = NUM_CORES'(1) << disp_idx;
    assign chunk_end  = eff_next + CHUNK_SIZE - NEXT_W'(1);
    assign next_adv   = eff_next + CHUNK_SIZE;
    assign chunk_last = (chunk_end > {1'b0, eff_last}) ? eff_last : chunk_end[NONCE_W-1:0];

    rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
        .clk       (hash_clk),
        .rst       (rst),
        .req       (disp_req),
        .advance   (do_start),
        .grant     (disp_grant),
        .grant_idx (disp_idx)
    );

    rr_arbiter #(.N(NUM_CORES)) u_found_arb (
        .clk       (hash_clk),
        .rst       (rst),
        .req       (pending_q),
        .advance   (!abort),
        .grant     (rep_grant),
        .grant_idx (rep_idx)
    );

    always_comb begin
        state_d    = state_q;
        job_done_d = 1'b0;
        if (new_work) begin
            state_d = eff_dispatch ? ST_DISPATCH : ST_DRAIN;
        end else if (state_q == ST_DRAIN && assigned_q == '0) begin
            state_d    = ST_IDLE;
            job_done_d = 1'b1;
        end
        if (do_start && next_adv > {1'b0, eff_last}) state_d = ST_DRAIN;
    end

    always_ff @(posedge hash_clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            next_q          <= '0;
            last_q          <= '0;
            assigned_q      <= '0;
            core_start      <= '0;
            core_abort      <= 1'b0;
            core_nonce_base <= '0;
            core_nonce_last <= '0;
            job_done        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_q    <= state_d;
            next_q     <= do_start ? next_adv : eff_next;
            last_q     <= eff_last;
            assigned_q <= eff_assigned | (do_start ? start_vec : '0);
            core_start <= do_start ? start_vec : '0;
            core_abort <= abort;
            job_done   <= job_done_d;
            busy       <= (state_d != ST_IDLE);
            if (do_start) begin
                core_nonce_base <= eff_next[NONCE_W-1:0];
                core_nonce_last <= chunk_last;
            end
        end
    end

    // A fresh find on a core being granted keeps pending set, so it is reported later.
    always_ff @(posedge hash_clk) begin
        if (rst) begin
            pending_q        <= '0;
            golden_nonce     <= '0;
            new_golden_nonce <= 1'b0;
            for (int unsigned i = 0; i < NUM_CORES; i++) hold_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (core_found[i]) hold_q[i] <= core_nonce[i*NONCE_W +: NONCE_W];
            end
            if (abort) begin
                pending_q <= '0;
            end else begin
                pending_q <= (pending_q & ~rep_grant) | core_found;
                if (|rep_grant) begin
                    golden_nonce     <= hold_q[rep_idx];
                    new_golden_nonce <= ~new_golden_nonce;
                end
            end
        end
    end

endmodule
